// File: rtl/demosaic_bayer_tx.sv
// Bayer RGGB raw-stream source with VSYNC/HSYNC framing and blanking, used as a sensor emulator.
// Optional BAYER_TX_LFSR_EN: PATTERN 3 becomes an LFSR noise field (otherwise constant mid-grey).
module demosaic_bayer_tx #(
  parameter int Cols     = 512,
  parameter int ActCols  = 480,
  parameter int Lines    = 768,
  parameter int ActLines = 720
) (
  input  logic       PCLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CONTINUOUS,
  input  logic [1:0] PATTERN,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic       VSYNC,
  output logic       HSYNC,
  output logic [7:0] BAYERDATA
);

  localparam logic [10:0] ColLast  = 11'(Cols - 1);
  localparam logic [10:0] LineLast = 11'(Lines - 1);
  localparam logic [10:0] ActColsW = 11'(ActCols);
  localparam logic [10:0] ActLinW  = 11'(ActLines);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [10:0] col_q, col_d;
  logic [10:0] line_q, line_d;
  logic [1:0]  pat_q, pat_d;
  logic        run, last_col, last_slot, frame_start;
  logic [7:0]  pix, pix_rnd;

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
    end
  end

  assign run       = (state_q == S_RUN);
  assign last_col  = (col_q == ColLast);
  assign last_slot = last_col && (line_q == LineLast);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    pat_d       = pat_q;
    frame_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d     = S_RUN;
          col_d       = '0;
          line_d      = '0;
          pat_d       = PATTERN;
          frame_start = 1'b1;
        end
      end
      S_RUN: begin
        if (last_slot) begin
          col_d  = '0;
          line_d = '0;
          // CONTINUOUS is sampled live at the frame boundary, so no idle gap between frames
          if (CONTINUOUS) begin
            pat_d       = PATTERN;
            frame_start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (last_col) begin
          col_d  = '0;
          line_d = line_q + 11'd1;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BAYER_TX_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  // x^8+x^6+x^5+x^4+1; advances only on active pixels so blanking holds the sequence
  always_comb begin
    lfsr_d = lfsr_q;
    if (frame_start)
      lfsr_d = 8'hA5;
    else if (HSYNC)
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign pix_rnd = lfsr_q;
`else
  assign pix_rnd = 8'h80;
`endif

  always_comb begin
    pix = 8'h00;
    case (pat_q)
      2'd0: pix = col_q[7:0];
      2'd1: pix = line_q[7:0];
      2'd2: begin
        if (!line_q[0] && !col_q[0])     pix = 8'hF0;
        else if (line_q[0] && col_q[0])  pix = 8'h10;
        else                             pix = 8'h80;
      end
      default: pix = pix_rnd;
    endcase
  end

  assign BUSY       = run;
  assign FRAME_DONE = run && last_slot;
  assign VSYNC      = run && (line_q < ActLinW);
  assign HSYNC      = VSYNC && (col_q < ActColsW);
  assign BAYERDATA  = HSYNC ? pix : 8'h00;

endmodule
